// File: rtl/wfunc_cfg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : wfunc_cfg_ctrl_if
// Brief    : Bus bundle for wfunc_cfg_ctrl. Carries the APB master port that
//            drives the window_func slave and the AXI-Stream coefficient
//            input. The master modport is the controller's view.
// Revision : 1.0 - initial release
// ============================================================================
interface wfunc_cfg_ctrl_if #(
    parameter int APB_AW = 16
);
    // APB towards the window_func slave
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_AW-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;

    // Coefficient stream from the DMA / ROM reader
    logic              s_tvalid;
    logic              s_tready;
    logic [31:0]       s_tdata;
    logic              s_tlast;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, s_tready,
        input  prdata, s_tvalid, s_tdata, s_tlast
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, s_tready,
        output prdata, s_tvalid, s_tdata, s_tlast
    );
endinterface
`default_nettype wire

// File: rtl/wfunc_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wfunc_cfg_ctrl
// Brief    : APB master that loads FFT_SIZE window coefficients from a
//            stream into a window_func instance, sets its mode bit, arms it
//            and polls its status until WAIT is reported.
// Revision : 1.0 - initial release
// ============================================================================
module wfunc_cfg_ctrl #(
    parameter int FFT_SIZE   = 8192,
    parameter int APB_AW     = $clog2(FFT_SIZE - 1) + 3,
    parameter int POLL_LIMIT = 255
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              start,
    input  wire              abort,
    input  wire              one_pack,
    wfunc_cfg_ctrl_if.master bus,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err
);
    localparam int c_KW = $clog2(FFT_SIZE);
    localparam int c_PW = $clog2(POLL_LIMIT + 1);
    localparam logic [APB_AW-1:0] c_CTRL_ADDR = APB_AW'(FFT_SIZE * 4);
    localparam logic [APB_AW-1:0] c_STAT_ADDR = APB_AW'((FFT_SIZE + 1) * 4);
    localparam logic [31:0] c_SRST_BIT = 32'h0000_0001;
    localparam logic [31:0] c_ARM_BIT  = 32'h0000_0100;

    localparam logic [3:0] c_ST_IDLE = 4'd0;
    localparam logic [3:0] c_ST_RST  = 4'd1;
    localparam logic [3:0] c_ST_MODE = 4'd2;
    localparam logic [3:0] c_ST_LOAD = 4'd3;
    localparam logic [3:0] c_ST_ARM  = 4'd4;
    localparam logic [3:0] c_ST_POLL = 4'd5;
    localparam logic [3:0] c_ST_DONE = 4'd6;
    localparam logic [3:0] c_ST_ERR  = 4'd7;
    localparam logic [3:0] c_ST_ABW  = 4'd8;   // abort: drain in-flight transfer
    localparam logic [3:0] c_ST_ABR  = 4'd9;   // abort: issue soft reset

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [APB_AW-1:0] r_paddr;
    logic [31:0]       r_pwdata;
    logic [31:0]       r_ctrl;
    logic [c_KW-1:0]   r_k;
    logic [c_PW-1:0]   r_poll_cnt;
    logic              r_one_pack;
    logic              r_end;        // terminal beat accepted, waiting for its write
    logic              r_end_ok;     // terminal beat had correct length
    logic [1:0]        r_err;
    logic              r_done;

    logic              w_setup;
    logic              w_access;
    logic              w_busy;
    logic              w_abort_go;
    logic              w_start_go;
    logic              w_tready;
    logic              w_hs;
    logic              w_k_last;
    logic              w_stat_ok;
    logic              w_poll_final;
    logic              w_launch;
    logic              w_write;
    logic [APB_AW-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ctrl_next;
    logic              w_unused_prdata;

    assign w_setup      = r_psel & ~r_penable;
    assign w_access     = r_psel & r_penable;
    assign w_busy       = ~((r_state == c_ST_IDLE) | (r_state == c_ST_DONE) | (r_state == c_ST_ERR));
    assign w_abort_go   = abort & w_busy & (r_state != c_ST_ABW) & (r_state != c_ST_ABR);
    assign w_start_go   = start & ~w_busy & ~abort;
    // A new beat may be taken when the bus is free or finishing its ACCESS.
    assign w_tready     = (r_state == c_ST_LOAD) & ~r_end & ~abort & (~r_psel | r_penable);
    assign w_hs         = bus.s_tvalid & w_tready;
    assign w_k_last     = (r_k == c_KW'(FFT_SIZE - 1));
    assign w_stat_ok    = (bus.prdata[9:8] == 2'b01);
    assign w_poll_final = (r_poll_cnt == c_PW'(POLL_LIMIT - 1));
    assign w_unused_prdata = ^{bus.prdata[31:10], bus.prdata[7:0]};

    assign bus.psel     = r_psel;
    assign bus.penable  = r_penable;
    assign bus.pwrite   = r_pwrite;
    assign bus.paddr    = r_paddr;
    assign bus.pwdata   = r_pwdata;
    assign bus.s_tready = w_tready;
    assign busy         = w_busy;
    assign done         = r_done;
    assign err          = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; every busy state leaves only when its transfer ends.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR: if (w_start_go) w_next = c_ST_RST;
            c_ST_RST:  if (w_access) w_next = c_ST_MODE;
            c_ST_MODE: if (w_access) w_next = c_ST_LOAD;
            c_ST_LOAD: if (w_access && r_end) w_next = r_end_ok ? c_ST_ARM : c_ST_ERR;
            c_ST_ARM:  if (w_access) w_next = c_ST_POLL;
            c_ST_POLL: begin
                if (w_access) begin
                    if (w_stat_ok)         w_next = c_ST_DONE;
                    else if (w_poll_final) w_next = c_ST_ERR;
                end
            end
            c_ST_ABW:  if (w_access) w_next = c_ST_ABR;
            c_ST_ABR:  if (w_access) w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
        // A transfer still in SETUP must finish its ACCESS before the soft reset.
        if (w_abort_go) w_next = w_setup ? c_ST_ABW : c_ST_ABR;
    end

    // Transfer launch decode: what SETUP, if any, starts on the next cycle.
    always_comb begin
        w_launch    = 1'b0;
        w_write     = 1'b1;
        w_addr      = c_CTRL_ADDR;
        w_wdata     = 32'h0;
        w_ctrl_next = r_ctrl;
        case (r_state)
            c_ST_RST, c_ST_ABR: begin
                if (!r_psel) begin
                    w_launch    = 1'b1;
                    w_ctrl_next = r_ctrl ^ c_SRST_BIT;
                    w_wdata     = r_ctrl ^ c_SRST_BIT;
                end
            end
            c_ST_MODE: begin
                if (!r_psel) begin
                    w_launch = 1'b1;
                    w_addr   = c_STAT_ADDR;
                    w_wdata  = {31'b0, r_one_pack};
                end
            end
            c_ST_LOAD: begin
                if (w_hs) begin
                    w_launch = 1'b1;
                    w_addr   = APB_AW'({r_k, 2'b00});
                    w_wdata  = bus.s_tdata;
                end
            end
            c_ST_ARM: begin
                if (!r_psel) begin
                    w_launch    = 1'b1;
                    w_ctrl_next = r_ctrl ^ c_ARM_BIT;
                    w_wdata     = r_ctrl ^ c_ARM_BIT;
                end
            end
            c_ST_POLL: begin
                if (!r_psel || (w_access && !w_stat_ok && !w_poll_final)) begin
                    w_launch = 1'b1;
                    w_write  = 1'b0;
                    w_addr   = c_STAT_ADDR;
                end
            end
            default: w_launch = 1'b0;
        endcase
        if (w_abort_go) begin
            w_launch    = 1'b0;
            w_ctrl_next = r_ctrl;
        end
    end

    // APB phase sequencing and ctrl shadow; the shadow moves at SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= 32'h0;
            r_ctrl    <= 32'h0;
        end else if (w_launch) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= w_write;
            r_paddr   <= w_addr;
            r_pwdata  <= w_wdata;
            r_ctrl    <= w_ctrl_next;
        end else if (w_setup) begin
            r_penable <= 1'b1;
        end else if (w_access) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end
    end

    // Sequence bookkeeping: coefficient index, poll count, error and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= '0;
            r_poll_cnt <= '0;
            r_one_pack <= 1'b0;
            r_end      <= 1'b0;
            r_end_ok   <= 1'b0;
            r_err      <= 2'b00;
            r_done     <= 1'b0;
        end else begin
            r_done <= (w_next == c_ST_DONE) && (r_state != c_ST_DONE);
            if (w_start_go) begin
                r_err      <= 2'b00;
                r_one_pack <= one_pack;
                r_k        <= '0;
                r_end      <= 1'b0;
                r_end_ok   <= 1'b0;
            end
            if (w_hs) begin
                r_k <= r_k + c_KW'(1);
                if (bus.s_tlast || w_k_last) begin
                    r_end    <= 1'b1;
                    r_end_ok <= bus.s_tlast && w_k_last;
                end
            end
            if (r_state != c_ST_POLL) r_poll_cnt <= '0;
            else if (w_access)        r_poll_cnt <= r_poll_cnt + c_PW'(1);
            if (r_state == c_ST_LOAD && w_next == c_ST_ERR) r_err <= 2'b01;
            if (r_state == c_ST_POLL && w_next == c_ST_ERR) r_err <= 2'b10;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wfunc_cfg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wfunc_cfg_ctrl
// Brief    : Self-checking bench for wfunc_cfg_ctrl with a transaction-level
//            expectation model, APB target stand-in and stream source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wfunc_cfg_ctrl;
    localparam int FFT = 8;
    localparam int AW  = 6;
    localparam int PL  = 4;
    localparam logic [AW-1:0] CTRL_A = 6'h20;
    localparam logic [AW-1:0] STAT_A = 6'h24;

    typedef struct { logic w; logic [AW-1:0] a; logic [31:0] d; } xfer_t;
    typedef struct { logic [31:0] d; logic l; } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic one_pack = 1'b0;
    logic busy;
    logic done;
    logic [1:0] err;

    int n_total = 0;
    int n_bad = 0;
    xfer_t exp_q[$];
    beat_t beat_q[$];
    logic [31:0] ctrl_log[$];
    int coef_cnt, rd_cnt, done_cnt, st_reads, st_ok_after, drv_mode;
    int mcyc = 0;
    int load_first, load_last;
    logic [31:0] m_ctrl;

    wfunc_cfg_ctrl_if #(.APB_AW(AW)) bus ();

    wfunc_cfg_ctrl #(.FFT_SIZE(FFT), .APB_AW(AW), .POLL_LIMIT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .one_pack(one_pack), .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        n_bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic push_exp(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        xfer_t x;
        x.w = w; x.a = a; x.d = d;
        exp_q.push_back(x);
    endtask

    // Target status register: [9:8]==01 (WAIT) from read st_ok_after onward.
    function automatic logic [31:0] status_word(input int n);
        logic [31:0] w;
        w = $urandom;
        if (st_ok_after >= 0 && n >= st_ok_after) w[9:8] = 2'b01;
        else if (w[9:8] == 2'b01) w[9:8] = 2'b11;
        return w;
    endfunction

    // Stream source: 0 = always valid, 1 = valid every other cycle, 2 = random.
    initial begin : p_drive
        bit hs_pend;
        bit tog;
        bit want;
        hs_pend = 1'b0;
        tog = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata = 32'h0;
        bus.s_tlast = 1'b0;
        forever begin
            @(negedge clk);
            if (hs_pend && beat_q.size() > 0) beat_q.delete(0);
            tog = ~tog;
            case (drv_mode)
                1:       want = tog;
                2:       want = (bus.s_tvalid && !hs_pend) || ($urandom_range(0, 1) == 1);
                default: want = 1'b1;
            endcase
            if (want && beat_q.size() > 0) begin
                bus.s_tvalid = 1'b1;
                bus.s_tdata  = beat_q[0].d;
                bus.s_tlast  = beat_q[0].l;
            end else begin
                bus.s_tvalid = 1'b0;
                bus.s_tdata  = $urandom;
                bus.s_tlast  = 1'($urandom_range(0, 1));
            end
            #2;
            hs_pend = bus.s_tvalid && bus.s_tready;
        end
    end

    // Compare process: APB protocol every cycle, each finished transfer
    // against the expected queue, and the target's read data.
    initial begin : p_mon
        logic ps, pw;
        logic [AW-1:0] pa;
        logic [31:0] pd;
        logic pdone;
        xfer_t x;
        ps = 1'b0; pw = 1'b0; pa = '0; pd = 32'h0; pdone = 1'b0;
        bus.prdata = 32'h0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst_n) begin
                ps = 1'b0;
                pdone = 1'b0;
            end else begin
                if (ps) begin
                    check("apb_hold", {28'b0, bus.psel, bus.penable, 1'b0, 1'b0} |
                          32'((bus.paddr != pa) || (bus.pwrite != pw) || (bus.pwdata != pd)),
                          32'h0000_000C);
                end else if (bus.penable) begin
                    fail("apb_enable_without_setup", 32'(bus.psel), 32'h0);
                end
                if (bus.s_tready && (!busy || (bus.psel && !bus.penable)))
                    fail("tready_illegal", 32'(busy), 32'h0);
                if (bus.psel && !busy) fail("psel_while_idle", 32'(bus.psel), 32'h0);
                if (done) begin
                    done_cnt++;
                    if (pdone) fail("done_width", 32'h2, 32'h1);
                end
                if (bus.psel && !bus.penable) begin
                    if (!bus.pwrite && bus.paddr == STAT_A) begin
                        bus.prdata = status_word(st_reads);
                        st_reads++;
                    end
                    if (bus.pwrite && bus.paddr == 6'h00 && load_first < 0) load_first = mcyc;
                end
                if (bus.psel && bus.penable) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_xfer", 32'(bus.paddr), 32'hFFFF_FFFF);
                    end else begin
                        x = exp_q.pop_front();
                        check("xfer_dir", 32'(bus.pwrite), 32'(x.w));
                        check("xfer_addr", 32'(bus.paddr), 32'(x.a));
                        if (x.w) check("xfer_wdata", bus.pwdata, x.d);
                    end
                    if (bus.pwrite && bus.paddr == CTRL_A) ctrl_log.push_back(bus.pwdata);
                    if (bus.pwrite && bus.paddr < CTRL_A) coef_cnt++;
                    if (bus.pwrite && bus.paddr == 6'h1C) load_last = mcyc;
                    if (!bus.pwrite && bus.paddr == STAT_A) rd_cnt++;
                end
                ps = bus.psel && !bus.penable;
                pw = bus.pwrite; pa = bus.paddr; pd = bus.pwdata;
                pdone = done;
            end
        end
    end

    // One configuration sequence: build the expected transfer list from the
    // sequence rules, drive start/abort, wait for the block to go idle.
    task automatic run_case(input string name, input logic op, input int last_idx,
                            input int ok_after, input int mode, input int abort_coef,
                            input bit mid_start, input bit fixed_data);
        int n_coef, n_reads, cnt, e_done;
        logic [1:0] e_err;
        bit aborted, mstarted, fin;
        beat_t b;
        logic [31:0] data[FFT];
        exp_q.delete(); ctrl_log.delete();
        coef_cnt = 0; rd_cnt = 0; done_cnt = 0; st_reads = 0;
        st_ok_after = ok_after; drv_mode = mode; load_first = -1; load_last = -1;
        n_coef = (last_idx < FFT) ? last_idx + 1 : FFT;
        for (int i = 0; i < n_coef; i++) begin
            data[i] = fixed_data ? 32'h0001_0000 + 32'(i) : $urandom;
            b.d = data[i];
            b.l = (i == last_idx);
            beat_q.push_back(b);
        end
        m_ctrl = m_ctrl ^ 32'h1;
        push_exp(1'b1, CTRL_A, m_ctrl);
        push_exp(1'b1, STAT_A, {31'b0, op});
        e_err = 2'b00;
        e_done = 0;
        if (abort_coef >= 0) begin
            for (int i = 0; i <= abort_coef; i++) push_exp(1'b1, AW'(i * 4), data[i]);
            m_ctrl = m_ctrl ^ 32'h1;
            push_exp(1'b1, CTRL_A, m_ctrl);
        end else begin
            for (int i = 0; i < n_coef; i++) push_exp(1'b1, AW'(i * 4), data[i]);
            if (last_idx == FFT - 1) begin
                m_ctrl = m_ctrl ^ 32'h100;
                push_exp(1'b1, CTRL_A, m_ctrl);
                if (ok_after >= 0 && ok_after < PL) begin
                    n_reads = ok_after + 1;
                    e_done = 1;
                end else begin
                    n_reads = PL;
                    e_err = 2'b10;
                end
                for (int r = 0; r < n_reads; r++) push_exp(1'b0, STAT_A, 32'h0);
            end else begin
                e_err = 2'b01;
            end
        end
        @(negedge clk); #1;
        one_pack = op;
        start = 1'b1;
        cnt = 0; aborted = 0; mstarted = 0; fin = 0;
        while (!fin) begin
            @(negedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            cnt++;
            if (abort_coef >= 0 && !aborted && bus.psel && bus.penable && bus.pwrite &&
                bus.paddr == AW'(abort_coef * 4)) begin
                abort = 1'b1;
                aborted = 1;
            end
            if (mid_start && !mstarted && bus.psel && bus.penable && bus.pwrite &&
                bus.paddr == 6'h0C) begin
                start = 1'b1;
                one_pack = ~op;
                mstarted = 1;
            end
            if (!busy && !abort && !start) fin = 1;
            if (cnt >= 600) begin
                fail({name, "_timeout"}, 32'(cnt), 32'h0);
                fin = 1;
            end
        end
        repeat (2) @(negedge clk);
        #1;
        check({name, "_pending_xfers"}, 32'(exp_q.size()), 32'h0);
        check({name, "_done_pulses"}, 32'(done_cnt), 32'(e_done));
        check({name, "_err"}, 32'(err), 32'(e_err));
        check({name, "_busy"}, 32'(busy), 32'h0);
        check({name, "_tready"}, 32'(bus.s_tready), 32'h0);
        beat_q.delete();
        one_pack = 1'b0;
    endtask

    initial begin : p_main
        int li, oa, ab;
        m_ctrl = 32'h0;
        drv_mode = 0;
        st_ok_after = 0;
        load_first = -1;
        load_last = -1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_psel", 32'(bus.psel), 32'h0);
        check("rst_penable", 32'(bus.penable), 32'h0);
        check("rst_pwrite", 32'(bus.pwrite), 32'h0);
        check("rst_paddr", 32'(bus.paddr), 32'h0);
        check("rst_pwdata", bus.pwdata, 32'h0);
        check("rst_tready", 32'(bus.s_tready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;

        // Full sequence with linear data, WAIT on the third status read.
        run_case("t1", 1'b1, 7, 2, 0, -1, 0, 1);
        check("t1_ctrl_writes", 32'(ctrl_log.size()), 32'd2);
        check("t1_ctrl_srst", ctrl_log[0], 32'h0000_0001);
        check("t1_ctrl_arm", ctrl_log[1], 32'h0000_0101);
        check("t1_coefs", 32'(coef_cnt), 32'd8);
        check("t1_load_cycles", 32'(load_last - load_first + 1), 32'd16);
        check("t1_reads", 32'(rd_cnt), 32'd3);

        // Restart: both command bits toggle back.
        run_case("t2", 1'b0, 7, 0, 0, -1, 0, 0);
        check("t2_ctrl_srst", ctrl_log[0], 32'h0000_0100);
        check("t2_ctrl_arm", ctrl_log[1], 32'h0000_0000);

        // Early tlast on beat 3.
        run_case("t3", 1'b1, 3, 0, 0, -1, 0, 0);
        check("t3_coefs", 32'(coef_cnt), 32'd4);
        check("t3_ctrl_writes", 32'(ctrl_log.size()), 32'd1);

        // Status never reports WAIT.
        run_case("t4", 1'b0, 7, 1000, 0, -1, 0, 0);
        check("t4_reads", 32'(rd_cnt), 32'd4);

        // Abort during ACCESS of coefficient 5.
        run_case("t5", 1'b1, 7, 0, 0, 5, 0, 0);
        check("t5_coefs", 32'(coef_cnt), 32'd6);
        check("t5_ctrl_writes", 32'(ctrl_log.size()), 32'd2);
        check("t5_ctrl_abort_srst", ctrl_log[1], 32'h0000_0100);

        // Gappy stream and a start pulse in the middle of LOAD.
        run_case("t6", 1'b1, 7, 1, 1, -1, 1, 0);
        check("t6_coefs", 32'(coef_cnt), 32'd8);

        // Randomised sequences.
        for (int t = 0; t < 10; t++) begin
            li = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 7;
            oa = int'($urandom_range(0, 5));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (li < FFT) ? li : FFT - 1)) : -1;
            run_case("rnd", 1'($urandom_range(0, 1)), li, oa, 2, ab, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wfunc_cfg_ctrl.md
Name: wfunc_cfg_ctrl

Overview:
APB master that configures and sequences one window_func instance without CPU involvement. It streams FFT_SIZE window coefficients from an AXI-Stream source into the window memory, sets the one-packet mode bit and arms the window_func FSM. It then polls the window_func status register until WAIT is reported. It sits between a coefficient source (DMA or ROM reader) and the window_func APB slave port; rst_n is shared with that window_func instance.

Parameters:
FFT_SIZE, 8192, window length; power of 2; must match the target window_func.
APB_AW, $clog2(FFT_SIZE-1)+3, APB address width; must match the target.
POLL_LIMIT, 255, maximum status reads in POLL before a timeout error.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begin a configuration sequence (honoured in IDLE, DONE, ERR only)
abort  in  1  1-cycle pulse; cancel the sequence and soft-reset the target
one_pack  in  1  value written to status-register bit 0; sampled on start
s_tvalid  in  1  coefficient stream valid
s_tready  out  1  coefficient stream ready
s_tdata  in  32  coefficient: [31:16] im, [15:0] re
s_tlast  in  1  last coefficient marker
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  APB_AW  APB byte address
pwdata  out  32  APB write data
prdata  in  32  APB read data, sampled at the end of the ACCESS phase
busy  out  1  high in every state except IDLE, DONE and ERR
done  out  1  1-cycle pulse on entry to DONE
err  out  2  sticky error code: 00 none, 01 stream length, 10 poll timeout; cleared on start

Behaviour:
- Reset values: psel, penable, pwrite, paddr, pwdata, s_tready, busy, done = 0; err = 00; state IDLE; ctrl shadow = 0.
- APB transfers: SETUP (psel=1, penable=0), then ACCESS (psel=1, penable=1). There is no pready, so every transfer takes exactly 2 cycles. paddr, pwrite and pwdata are held stable across both phases. Outside transfers psel = penable = 0.
- Command encoding: the target detects a command as a change in a control-register bit.
  - The block keeps a 32-bit ctrl shadow; bits 0 and 8 are the only non-zero bits.
  - Soft reset: invert shadow[0], then write the shadow to address FFT_SIZE*4.
  - Change state: invert shadow[8], then write the shadow to address FFT_SIZE*4.
  - The shadow is updated at the SETUP of that write.
- States and transitions:
  - IDLE: on start go to RST. Clear err, latch one_pack, clear the coefficient counter k.
  - RST: issue a soft-reset command, then go to MODE.
  - MODE: write {31'b0, one_pack} to address (FFT_SIZE+1)*4, then go to LOAD.
  - LOAD: write each coefficient to address k*4 and increment k. The target applies its own address bit-reversal; this block always writes linear addresses.
    - s_tready=1 in LOAD when no transfer is in flight or the current transfer is in ACCESS. A handshake in an ACCESS cycle starts the next SETUP in the following cycle, so sustained throughput is 1 coefficient per 2 cycles.
    - Beat k=FFT_SIZE-1 with s_tlast=1: the write completes, then go to ARM.
    - s_tlast=1 on any k<FFT_SIZE-1, or s_tlast=0 on k=FFT_SIZE-1: the write completes, s_tready drops, err=01, go to ERR.
  - ARM: issue a change-state command, then go to POLL.
  - POLL: read address (FFT_SIZE+1)*4 repeatedly, back to back.
    - prdata[9:8]==01: go to DONE.
    - POLL_LIMIT reads complete without 01: err=10, go to ERR.
  - DONE / ERR: idle, busy=0; start restarts at RST.
- abort in any busy state:
  - Any in-flight transfer completes; penable is never cut short.
  - A soft-reset command is then issued, then go to IDLE with no done pulse and err unchanged.
  - abort in IDLE, DONE or ERR is ignored.
  - abort and start in the same cycle: abort wins.
- start while busy is ignored.
- s_tready is 0 outside LOAD. Stream beats arriving while s_tready=0 are not consumed.
- k is $clog2(FFT_SIZE) bits wide.

Test Plan:
1. FFT_SIZE=8, one_pack=1, 8 beats with data 0x0001_0000+i and tlast on beat 7 → ctrl write 0x1 at 0x20, then 0x1 at 0x24, then data 0x0001_0000+i at addresses 4i for i=0..7, then ctrl write 0x101, then reads until status 0x1xx; done pulses once; err=00; 16 cycles minimum for the LOAD phase.
2. Second start after test 1 → ctrl writes 0x100 (soft reset) then 0x000 (arm), confirming bit toggling.
3. tlast on beat 3 of 8 → exactly 4 coefficient writes, no arm write, err=01, busy=0, s_tready=0 afterwards.
4. POLL_LIMIT=4 with the target's prdata[9:8] stuck at 00 → exactly 4 status reads, then err=10 and no done.
5. abort during the ACCESS phase of coefficient 5 → that write completes with penable held high for 1 cycle, then a soft-reset ctrl write, then IDLE; no done pulse.
6. s_tvalid toggling every other cycle, with start asserted mid-LOAD → all 8 addresses written in order, start has no effect, APB protocol holds (no SETUP without a following ACCESS).
